// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC interpolator sequencer.
//   ctrl_state_t : sequencer state encoding (IDLE=0, WARMUP=1, RUN=2, STOPPING=3)
//   FIFO_DEPTH   : number of base-rate samples buffered ahead of the CIC
//   warmup_len() : number of enabled cycles before the CIC output is trusted
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } ctrl_state_t;

  localparam int FIFO_DEPTH = 2;

  // Every CIC stage needs one full input period to flush before its output
  // reflects real data, so the warm-up spans STAGES input periods.
  function automatic int warmup_len(input int stages, input int rate);
    return stages * rate;
  endfunction

endpackage

// File: rtl/cic_ctrl_fifo.sv
// Small synchronous FIFO that buffers upstream samples for the sequencer.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   push, wr_data  : write request and data; ignored while full
//   pop            : read request; ignored while empty
//   full, empty    : occupancy flags
//   head           : oldest stored entry (valid only when !empty)
// A push while full is dropped even if a pop happens in the same cycle.
module cic_ctrl_fifo
  import cic_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cic_interp_ctrl.sv
// Sequencer for the CIC interpolator: buffers base-rate samples, presents one
// to the CIC every INTERP_RATE clocks, drives the CIC enable, masks the CIC
// output valid during pipeline warm-up and flags input underflow.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   run            : 1 = stream, 0 = stop at the next sample boundary
//   s_valid/s_data/s_ready : upstream sample handshake (s_ready = !full)
//   cic_enable     : CIC clock enable, high outside IDLE
//   cic_data_in    : registered sample to the CIC (zero-stuffed on underflow)
//   cic_valid      : CIC data_valid
//   out_valid      : cic_valid qualified by the RUN state
//   phase          : interpolation phase counter
//   load_strobe    : high in the cycle whose clock edge updates cic_data_in
//   underflow      : high at a load point that finds the FIFO empty
//   state          : IDLE=0, WARMUP=1, RUN=2, STOPPING=3
//   underflow_cnt  : saturating underflow count
// Build option: define CIC_CTRL_UFCNT_EN to build the underflow counter;
// otherwise underflow_cnt is tied to zero.
module cic_interp_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH   = 4,
  parameter int STAGES      = 3,
  parameter int INTERP_RATE = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic                           s_valid,
  input  logic [BIT_WIDTH-1:0]           s_data,
  output logic                           s_ready,
  output logic                           cic_enable,
  output logic [BIT_WIDTH-1:0]           cic_data_in,
  input  logic                           cic_valid,
  output logic                           out_valid,
  output logic [$clog2(INTERP_RATE)-1:0] phase,
  output logic                           load_strobe,
  output logic                           underflow,
  output logic [1:0]                     state,
  output logic [15:0]                    underflow_cnt
);

  localparam int PW = $clog2(INTERP_RATE);
  localparam int WL = warmup_len(STAGES, INTERP_RATE);
  localparam int WW = (WL > 1) ? $clog2(WL) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(INTERP_RATE - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'(WL - 1);

  ctrl_state_t          state_reg, state_next;
  logic [PW-1:0]        phase_reg, phase_next;
  logic [WW-1:0]        warm_reg, warm_next;
  logic [BIT_WIDTH-1:0] data_reg, data_next;
  logic                 ready_en_reg;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [BIT_WIDTH-1:0] fifo_head;
  logic                 load_point;
  logic                 phase_last;

  cic_ctrl_fifo #(
    .WIDTH (BIT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (s_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // s_ready stays low while in reset and for the cycle of release, so no
  // sample can be accepted on the very edge that leaves reset.
  assign s_ready    = ready_en_reg && !fifo_full;
  assign fifo_push  = s_valid && s_ready;
  assign phase_last = (phase_reg == PHASE_LAST);
  assign load_point = ((state_reg == WARMUP) || (state_reg == RUN)) && (phase_reg == '0);
  assign fifo_pop   = load_point && !fifo_empty;

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    warm_next  = '0;
    data_next  = data_reg;

    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (run) state_next = WARMUP;
      end
      WARMUP: begin
        warm_next = warm_reg + WW'(1);
        // A stop requested on the last phase lands exactly on the boundary,
        // so there is nothing left to drain.
        if (!run)                      state_next = phase_last ? IDLE : STOPPING;
        else if (warm_reg == WARM_LAST) state_next = RUN;
      end
      RUN: begin
        if (!run) state_next = phase_last ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (phase_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE) begin
      phase_next = phase_last ? '0 : phase_reg + PW'(1);
    end

    if (load_point) begin
      data_next = fifo_empty ? '0 : fifo_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      warm_reg     <= '0;
      data_reg     <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      warm_reg     <= warm_next;
      data_reg     <= data_next;
      ready_en_reg <= 1'b1;
    end
  end

  assign cic_enable  = (state_reg != IDLE);
  assign out_valid   = (state_reg == RUN) && cic_valid;
  assign cic_data_in = data_reg;
  assign phase       = phase_reg;
  assign load_strobe = load_point;
  assign underflow   = load_point && fifo_empty;
  assign state       = state_reg;

`ifdef CIC_CTRL_UFCNT_EN
  logic [15:0] uf_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_cnt_reg <= '0;
    end else if (underflow && (uf_cnt_reg != 16'hFFFF)) begin
      uf_cnt_reg <= uf_cnt_reg + 16'd1;
    end
  end

  assign underflow_cnt = uf_cnt_reg;
`else
  assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cic_interp_ctrl.sv
// Self-checking bench for cic_interp_ctrl. A behavioural model (sample queue,
// cycle count since enable, stop flag) predicts every output each cycle;
// directed scenarios add literal expectations, then a randomized run follows.
`timescale 1ns/1ps
module tb_cic_interp_ctrl;

  localparam int BW = 4;
  localparam int STG = 3;
  localparam int R = 4;
  localparam int WL = STG * R;
`ifdef CIC_CTRL_UFCNT_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0;
  logic          s_valid = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic          cic_valid = 1'b0;
  logic          s_ready, cic_enable, out_valid, load_strobe, underflow;
  logic [BW-1:0] cic_data_in;
  logic [1:0]    phase;
  logic [1:0]    state;
  logic [15:0]   underflow_cnt;

  cic_interp_ctrl #(.BIT_WIDTH(BW), .STAGES(STG), .INTERP_RATE(R)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .cic_enable(cic_enable), .cic_data_in(cic_data_in),
    .cic_valid(cic_valid), .out_valid(out_valid), .phase(phase),
    .load_strobe(load_strobe), .underflow(underflow), .state(state),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [BW-1:0] mq[$];
  bit            m_ready, m_en, m_stop;
  int            m_t;
  logic [BW-1:0] m_data;
  int            m_uf;
  bit            mv_ld, mv_push, mv_last;

  function automatic int m_state_f();
    if (!m_en) return 0;
    if (m_stop) return 3;
    return (m_t < WL) ? 1 : 2;
  endfunction

  function automatic int m_phase_f();
    return m_en ? (m_t % R) : 0;
  endfunction

  function automatic bit m_load_f();
    return m_en && !m_stop && ((m_t % R) == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready = 0; m_en = 0; m_stop = 0; m_t = 0; m_data = '0; m_uf = 0;
    end else begin
      mv_ld   = m_load_f();
      mv_push = s_valid && m_ready && (mq.size() < 2);
      mv_last = ((m_t % R) == R - 1);
      if (mv_ld) begin
        if (mq.size() > 0) m_data = mq.pop_front();
        else begin
          m_data = '0;
          if (UF_EN && m_uf < 65535) m_uf++;
        end
      end
      if (mv_push) mq.push_back(s_data);
      if (!m_en) begin
        if (run) begin m_en = 1; m_t = 0; m_stop = 0; end
      end else if (m_stop || !run) begin
        if (mv_last) begin m_en = 0; m_stop = 0; m_t = 0; end
        else begin m_stop = 1; m_t++; end
      end else begin
        m_t++;
      end
      m_ready = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("s_ready", s_ready, (m_ready && mq.size() < 2));
    check("cic_enable", cic_enable, m_en);
    check("cic_data_in", cic_data_in, m_data);
    check("out_valid", out_valid, (m_state_f() == 2) && cic_valid);
    check("phase", phase, m_phase_f());
    check("load_strobe", load_strobe, m_load_f());
    check("underflow", underflow, m_load_f() && mq.size() == 0);
    check("state", state, m_state_f());
    check("underflow_cnt", underflow_cnt, m_uf);
  end

  // ---------------- load monitor ----------------
  logic [BW-1:0] obs_val[$];
  bit            obs_uf[$];
  bit            ld_pend = 0;

  always @(negedge clk) begin
    if (!rst_n) ld_pend = 0;
    else begin
      if (ld_pend) obs_val.push_back(cic_data_in);
      ld_pend = load_strobe;
      if (load_strobe) obs_uf.push_back(underflow);
    end
  end

  initial forever begin
    @(posedge clk);
    #2 cic_valid = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; s_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    obs_val.delete(); obs_uf.delete();
  endtask

  task automatic wait_loads(input int n, input string name);
    int k = 0;
    while (obs_val.size() < n && k < 500) begin tick(); k++; end
    check(name, (obs_val.size() >= n), 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (state != 2'd0 && k < 100) begin tick(); k++; end
    check(name, state, 0);
  endtask

  logic [BW-1:0] seq [8];
  logic [BW-1:0] bp_first;
  bit            hs;
  int            i, k, n;

  initial begin
    seq = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF};

    // 1: reset held with s_valid high
    #1 rst_n = 1'b0;
    s_valid = 1'b1;
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_cic_enable", cic_enable, 0);
    check("rst_state", state, 0);
    check("rst_data", cic_data_in, 0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    check("release_s_ready", s_ready, 0);
    tick();
    check("post_release_s_ready", s_ready, 1);

    // 2: steady stream kept ahead of demand
    do_reset();
    run = 1'b1; i = 0; k = 0;
    while (i < 8 && k < 200) begin
      s_valid = 1'b1; s_data = seq[i]; hs = s_ready;
      tick();
      if (hs) i++;
      k++;
    end
    s_valid = 1'b0;
    check("stream_pushes", i, 8);
    wait_loads(8, "stream_load_timeout");
    for (int j = 0; j < 8 && j < obs_val.size(); j++) begin
      check($sformatf("stream_val%0d", j), obs_val[j], seq[j]);
      check($sformatf("stream_uf%0d", j), obs_uf[j], 0);
    end
    run = 1'b0;
    wait_idle("stream_stop_idle");

    // 3: starvation after two samples
    do_reset();
    s_valid = 1'b1; s_data = 4'h3; tick();
    s_data = 4'h5; tick();
    s_valid = 1'b0; run = 1'b1;
    wait_loads(3, "starve_load_timeout");
    if (obs_val.size() >= 3) begin
      check("starve_val0", obs_val[0], 4'h3);
      check("starve_val1", obs_val[1], 4'h5);
      check("starve_val2", obs_val[2], 4'h0);
      check("starve_uf2", obs_uf[2], 1);
      check("starve_uf_cnt", underflow_cnt, UF_EN ? 1 : 0);
    end
    run = 1'b0;
    wait_idle("starve_stop_idle");

    // 4: backpressure, third push refused
    do_reset();
    bp_first = BW'($urandom);
    n = 0;
    for (int j = 0; j < 3; j++) begin
      s_valid = 1'b1;
      s_data = (j == 0) ? bp_first : BW'($urandom);
      hs = s_ready;
      if (hs) n++;
      tick();
    end
    s_valid = 1'b0;
    check("bp_accepted", n, 2);
    check("bp_s_ready_full", s_ready, 0);
    run = 1'b1;
    tick();
    check("bp_load_cycle_strobe", load_strobe, 1);
    check("bp_load_cycle_ready", s_ready, 0);
    tick();
    check("bp_ready_after_pop", s_ready, 1);
    check("bp_first_data", cic_data_in, bp_first);

    // 5: stop with run falling during phase 0 -> STOPPING covers phases 1..3
    k = 0;
    while (!(state == 2'd2 && phase == 2'd0) && k < 100) begin tick(); k++; end
    check("stop_reach_run", state, 2);
    run = 1'b0;
    tick();
    n = 0;
    while (state == 2'd3 && n < 20) begin n++; tick(); end
    check("stop_cycles", n, 3);
    check("stop_idle_state", state, 0);
    check("stop_idle_enable", cic_enable, 0);
    run = 1'b1;
    tick();
    n = 0;
    while (state == 2'd1 && n < 40) begin n++; tick(); end
    check("rewarm_cycles", n, WL);
    check("rewarm_run", state, 2);

    // 6: async reset at phase 2 in RUN with one buffered sample
    k = 0;
    while (!(state == 2'd2 && phase == 2'd1) && k < 100) begin tick(); k++; end
    s_valid = 1'b1; s_data = 4'h7;
    tick();
    s_valid = 1'b0;
    check("areset_pre_phase", phase, 2);
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", state, 0);
    check("areset_enable", cic_enable, 0);
    check("areset_phase", phase, 0);
    check("areset_data", cic_data_in, 0);
    check("areset_ready", s_ready, 0);
    run = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    obs_val.delete(); obs_uf.delete();
    run = 1'b1;
    wait_loads(1, "areset_load_timeout");
    if (obs_uf.size() >= 1) begin
      check("areset_first_uf", obs_uf[0], 1);
      check("areset_first_val", obs_val[0], 0);
    end
    run = 1'b0;
    wait_idle("areset_stop_idle");

    // 7: randomized stream with one mid-cycle reset pulse
    do_reset();
    for (int c = 0; c < 600; c++) begin
      run = ($urandom_range(0, 15) != 0);
      s_valid = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      s_data = BW'($urandom);
      if (c == 450) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end
    run = 1'b0; s_valid = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
